// File: rtl/isochronous_hs_pkg.sv
// Shared helpers and types for the isochronous handshake source buffer.
package isochronous_hs_pkg;

   // Width of an occupancy counter that must hold every value from 0 to depth.
   function automatic int fill_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Saturation limit of the stall watchdog counter, in cycles.
   typedef int unsigned stall_limit_t;

endpackage

// File: rtl/isochronous_hs_stall_counter.sv
// Stall watchdog for the offered head word: counts the cycles in which the
// head is offered but not accepted, saturates at STALL_CYCLES, and raises
// stall_o once the limit is reached.  Included when the top is built with
// ISOCHRONOUS_HS_STALL_WATCHDOG_EN.
module isochronous_hs_stall_counter
   import isochronous_hs_pkg::*;
#(
   parameter stall_limit_t STALL_CYCLES = 64
)
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic ready_i,
   output logic stall_o
);

   localparam int CNT_W = $clog2(STALL_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             stall_r;

   // Next count: clear on acceptance or idle, otherwise count up to the limit.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (!valid_i || ready_i) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r != LIMIT) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter and stall flag registers; the flag drops the cycle after a pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r   <= {CNT_W{1'b0}};
         stall_r <= 1'b0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         stall_r <= (cnt_nxt_s == LIMIT);
      end
   end

   assign stall_o = stall_r;

endmodule

// File: rtl/isochronous_hs_src_buffer.sv
// Source-side staging FIFO in front of the isochronous 4-phase handshake.
// The head word and its valid flag come only from registers, so they stay
// stable while offered.  Optional stall watchdog: ISOCHRONOUS_HS_STALL_WATCHDOG_EN.
module isochronous_hs_src_buffer
   import isochronous_hs_pkg::*;
#(
   parameter int           DATA_WIDTH   = 32,
   parameter int           DEPTH        = 4,
   parameter stall_limit_t STALL_CYCLES = 64
)
(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          up_valid_i,
   output logic                          up_ready_o,
   input  logic [DATA_WIDTH-1:0]         up_data_i,
   output logic                          hs_valid_o,
   input  logic                          hs_ready_i,
   output logic [DATA_WIDTH-1:0]         hs_data_o,
   output logic [fill_width(DEPTH)-1:0]  fill_o,
   output logic                          stall_o
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = fill_width(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

   // Reject parameter values the pointer arithmetic cannot support.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (STALL_CYCLES == 32'd0) begin : g_bad_stall
      $error("STALL_CYCLES must be at least 1");
   end

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_nxt_s;
   logic [PTR_W-1:0]      wr_ptr_nxt_s;
   logic [FILL_W-1:0]     fill_r;
   logic [FILL_W-1:0]     fill_nxt_s;
   logic                  valid_r;
   logic                  full_s;
   logic                  push_s;
   logic                  pop_s;

   // A full buffer refuses pushes even if the head pops this cycle.
   assign full_s     = (fill_r == FILL_FULL);
   assign up_ready_o = !full_s && !flush_i;
   assign push_s     = up_valid_i && up_ready_o;
   assign pop_s      = valid_r && hs_ready_i;

   assign hs_valid_o = valid_r;
   assign hs_data_o  = mem_r[rd_ptr_r];
   assign fill_o     = fill_r;

   // Pointer and occupancy update; a flush keeps only a head that is still offered.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      fill_nxt_s   = fill_r;
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (flush_i) begin
         if (valid_r && !pop_s) begin
            fill_nxt_s   = FILL_ONE;
            wr_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         end else begin
            fill_nxt_s   = {FILL_W{1'b0}};
            wr_ptr_nxt_s = rd_ptr_nxt_s;
         end
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         fill_nxt_s = fill_r + FILL_W'(push_s) - FILL_W'(pop_s);
      end
   end

   // State registers and storage; reset clears every entry so the head reads zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         fill_r   <= {FILL_W{1'b0}};
         valid_r  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         fill_r   <= fill_nxt_s;
         valid_r  <= (fill_nxt_s != {FILL_W{1'b0}});
         if (push_s) begin
            mem_r[wr_ptr_r] <= up_data_i;
         end
      end
   end

`ifdef ISOCHRONOUS_HS_STALL_WATCHDOG_EN
   isochronous_hs_stall_counter #(
      .STALL_CYCLES (STALL_CYCLES)
   ) u_stall_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_r),
      .ready_i (hs_ready_i),
      .stall_o (stall_o)
   );
`else
   assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_isochronous_hs_src_buffer.sv
// Directed, scoreboard-checked bench for isochronous_hs_src_buffer.
module tb_isochronous_hs_src_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int STALL = 8;
   localparam int FW    = $clog2(DEPTH + 1);
`ifdef ISOCHRONOUS_HS_STALL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          up_valid_i = 1'b0;
   logic          up_ready_o;
   logic [DW-1:0] up_data_i = '0;
   logic          hs_valid_o;
   logic          hs_ready_i = 1'b0;
   logic [DW-1:0] hs_data_o;
   logic [FW-1:0] fill_o;
   logic          stall_o;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] sb[$];
   int            sent;
   bit            pushed;

   isochronous_hs_src_buffer #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .STALL_CYCLES (STALL)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .up_valid_i (up_valid_i),
      .up_ready_o (up_ready_o),
      .up_data_i  (up_data_i),
      .hs_valid_o (hs_valid_o),
      .hs_ready_i (hs_ready_i),
      .hs_data_o  (hs_data_o),
      .fill_o     (fill_o),
      .stall_o    (stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check pre-edge outputs, update the model at the edge, check post-edge outputs.
   task automatic tick(output bit did_push);
      bit            exp_rdy;
      bit            do_pop;
      bit            do_push;
      logic [DW-1:0] dat;
      logic [DW-1:0] tmp;
      #1;
      exp_rdy = (sb.size() < DEPTH) && !flush_i;
      do_pop  = (sb.size() != 0) && hs_ready_i;
      do_push = up_valid_i && exp_rdy && !rst_i;
      dat     = up_data_i;
      if (!rst_i) begin
         chk("up_ready", up_ready_o, exp_rdy);
         if (do_pop) chk("pop_data", hs_data_o, sb[0]);
      end
      @(posedge clk_i);
      if (rst_i) begin
         sb.delete();
      end else begin
         if (flush_i) begin
            if ((sb.size() != 0) && !do_pop) begin
               while (sb.size() > 1) tmp = sb.pop_back();
            end else begin
               sb.delete();
            end
         end else begin
            if (do_pop) tmp = sb.pop_front();
            if (do_push) sb.push_back(dat);
         end
      end
      did_push = do_push;
      @(negedge clk_i);
      chk("fill", fill_o, sb.size());
      chk("hs_valid", hs_valid_o, sb.size() != 0);
      if (sb.size() != 0) chk("hs_data", hs_data_o, sb[0]);
   endtask

   initial begin
      // Reset state
      @(negedge clk_i);
      rst_i = 1'b1;
      tick(pushed);
      rst_i = 1'b0;
      chk("rst_data", hs_data_o, 32'h0);
      chk("rst_ready", up_ready_o, 1'b1);
      chk("rst_stall", stall_o, 1'b0);

      // Single push, head held while not accepted
      up_valid_i = 1'b1; up_data_i = 32'hA5A5_0001;
      tick(pushed);
      up_valid_i = 1'b0;
      chk("first_head", hs_data_o, 32'hA5A5_0001);
      for (int i = 0; i < 10; i++) tick(pushed);

      // Fill to full, then one pop
      for (int i = 2; i <= 4; i++) begin
         up_valid_i = 1'b1; up_data_i = 32'hA5A5_0000 + 32'(i);
         tick(pushed);
      end
      up_valid_i = 1'b0;
      #1 chk("full_ready", up_ready_o, 1'b0);
      chk("full_fill", fill_o, 3'd4);
      hs_ready_i = 1'b1;
      tick(pushed);
      hs_ready_i = 1'b0;
      chk("after_pop_fill", fill_o, 3'd3);
      chk("after_pop_ready", up_ready_o, 1'b1);
      chk("after_pop_head", hs_data_o, 32'hA5A5_0002);

      // Streaming with toggling ready
      sent = 0;
      for (int cyc = 0; cyc < 200 && sent < 20; cyc++) begin
         up_valid_i = 1'b1; up_data_i = 32'h100 + 32'(sent);
         hs_ready_i = (cyc % 2) == 0;
         tick(pushed);
         if (pushed) sent++;
      end
      chk("stream_sent", sent, 20);
      up_valid_i = 1'b0; hs_ready_i = 1'b1;
      for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) tick(pushed);
      hs_ready_i = 1'b0;
      chk("drained_valid", hs_valid_o, 1'b0);
      chk("drained_fill", fill_o, 3'd0);

      // Flush with head offered and not accepted
      for (int i = 1; i <= 3; i++) begin
         up_valid_i = 1'b1; up_data_i = 32'hF0 + 32'(i);
         tick(pushed);
      end
      flush_i = 1'b1; up_data_i = 32'hDEAD;
      #1 chk("flush_ready", up_ready_o, 1'b0);
      tick(pushed);
      flush_i = 1'b0; up_valid_i = 1'b0;
      chk("flush_fill", fill_o, 3'd1);
      chk("flush_head", hs_data_o, 32'hF1);

      // Reset with three words stored
      for (int i = 2; i <= 3; i++) begin
         up_valid_i = 1'b1; up_data_i = 32'hC0 + 32'(i);
         tick(pushed);
      end
      up_valid_i = 1'b0;
      chk("pre_rst_fill", fill_o, 3'd3);
      rst_i = 1'b1;
      tick(pushed);
      rst_i = 1'b0;
      chk("mid_rst_valid", hs_valid_o, 1'b0);
      chk("mid_rst_fill", fill_o, 3'd0);
      chk("mid_rst_data", hs_data_o, 32'h0);

      // Stall watchdog
      up_valid_i = 1'b1; up_data_i = 32'hB0;
      tick(pushed);
      up_valid_i = 1'b0;
      for (int i = 0; i < STALL - 1; i++) tick(pushed);
      chk("stall_early", stall_o, 1'b0);
      tick(pushed);
      chk("stall_set", stall_o, WD_EN);
      hs_ready_i = 1'b1;
      #1 chk("stall_in_pop", stall_o, WD_EN);
      tick(pushed);
      hs_ready_i = 1'b0;
      chk("stall_clear", stall_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
